movegen_dispatcher: RTL and testbench
=====================================

// Module: movegen_dispatcher
// PURPOSE
//  Sequencer that sits between the HPS and the per-piece move-generator
//  accelerators (pawn, rook, knight, bishop, queen, king).
//  - Reads one 64-square board from SDRAM.
//  - For every piece of the requested colour, programs and starts the
//    matching generator's CSRs, then waits for it to finish.
//  - Lays the generated boards out contiguously from a destination base.
//  - Reports the total number of boards generated.
// PARAMETERS
//  GEN_BASE    32'h0000_1000  byte address of the pawn generator CSR block
//  GEN_STRIDE  32'h0000_0040  byte spacing between generator CSR blocks
//  BOARD_BYTES 64             bytes per board (1 signed byte per square)
// PORTS
//  clk                   in   1   clock
//  rst                   in   1   async, active-high reset
//  slave_waitrequest     out  1   HPS CSR stall
//  slave_address         in   4   CSR word index
//  slave_read            in   1   CSR read strobe
//  slave_readdata        out  32  CSR read data
//  slave_write           in   1   CSR write strobe
//  slave_writedata       in   32  CSR write data
//  mem_waitrequest       in   1   SDRAM stall
//  mem_address           out  32  SDRAM byte address (word aligned)
//  mem_read              out  1   SDRAM read strobe
//  mem_readdata          in   32  4 squares; byte k = square base+k
//  mem_readdatavalid     in   1   SDRAM read data valid
//  gen_waitrequest       in   1   generator CSR stall
//  gen_address           out  32  generator CSR byte address
//  gen_read              out  1   generator CSR read strobe
//  gen_readdata          in   32  generator reg0 read = boards written
//  gen_write             out  1   generator CSR write strobe
//  gen_writedata         out  32  generator CSR write data
// BEHAVIOUR
//  CSR map:
//  - 0: write = start (ignored while busy); read = {ovf[31], 23'b0, count[7:0]}.
//    A read of 0 holds waitrequest=1 while busy and releases it in the DONE cycle.
//  - 1: board addr.  2: dest base.  3: colour (bit0: 0 = white >0, 1 = black <0).
//  - 4: max_boards (8 bits).
//  - All other accesses complete with waitrequest=0.
//  - Readdata is combinational from the registers.
//  Reset: all regs 0; all strobes 0; slave_waitrequest 0; state IDLE.
//  Reset mid-operation aborts at once; the generator is left unprogrammed.
//  Square index sq = y*8 + x.
//  Piece type from |v|: 1-8 pawn(0), 9-18 rook(1), 19-28 knight(2),
//  29-38 bishop(3), 39-47 queen(4), 48 king(5). 0 = empty, skipped.
//  FSM:
//  - IDLE: start -> FETCH; sq=0, count=0, ovf=0, dst=dest base.
//  - FETCH: mem_read to board+sq (sq%4==0). Hold address and strobe while
//    mem_waitrequest is high. Deassert after acceptance. Latch the word on
//    readdatavalid -> SCAN.
//  - SCAN: one square per cycle, lanes 0..3.
//    - Own-colour piece -> CFG.
//    - Otherwise sq++.
//    - After lane 3: sq==64 -> DONE, else FETCH.
//  - CFG: five gen writes to GEN_BASE + type*GEN_STRIDE + 4*r, in order r=1..4,0.
//    - Data: board addr, dst, x=sq%8, y=sq/8, 0.
//    - Each write holds while gen_waitrequest is high.
//    - Then -> POLL.
//  - POLL: gen_read reg0, held until gen_waitrequest drops; n = gen_readdata[7:0].
//    - count += n; dst += n*64.
//    - count >= max_boards -> ovf=1, DONE.
//    - Else sq++ and continue SCAN/FETCH.
//  - DONE: one cycle, releases a pending status read -> IDLE.
//  Width and arithmetic rules:
//  - count saturates at 255.
//  - dst arithmetic is 32-bit and wraps.
//  - max_boards=0 means unlimited.
//  Exclusivity: at most one of mem_read, gen_read, gen_write is high at a time.
// STRUCTURE
//  Shared package movegen_pkg:
//  - piece constants and range bounds;
//  - piece_type_e {PAWN..KING};
//  - CSR index localparams shared with the generators.
//  Sub-module piece_decode (combinational):
//  - in: signed byte, colour; out: own, type.
// TESTING
//  1 Reset: assert rst mid-FETCH -> all strobes 0 next cycle; status read = 0.
//  2 Board with white pawn at x=2,y=1, colour 0, gen mock returns 2
//    -> writes to 0x1004..0x1010 = board, dest, 2, 1, then 0x1000;
//    status = 2.
//  3 White knight at sq 1 and bishop at sq 2, mock returns 3 then 4
//    -> knight block at 0x1080 gets dst = dest;
//    bishop block at 0x10C0 gets dst = dest+192; count = 7.
//  4 Colour=1 on the initial board -> only negative pieces dispatched;
//    16 dispatches; 16 mem reads.
//  5 max_boards=3, mock returns 2 per piece -> stops after 2nd dispatch;
//    status = 0x8000_0004.
//  6 Random mem/gen waitrequest (30%) and a start while busy -> identical
//    transaction trace to the stall-free run; the extra start is ignored.

Source files
------------

// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generator dispatcher
// and the per-piece generator CSR blocks.
package movegen_pkg;

    localparam logic [31:0] GEN_BASE    = 32'h0000_1000;
    localparam logic [31:0] GEN_STRIDE  = 32'h0000_0040;
    localparam int          BOARD_BYTES = 64;

    // Upper |value| bound of each piece class
    localparam logic [7:0] PAWN_MAX   = 8'd8;
    localparam logic [7:0] ROOK_MAX   = 8'd18;
    localparam logic [7:0] KNIGHT_MAX = 8'd28;
    localparam logic [7:0] BISHOP_MAX = 8'd38;
    localparam logic [7:0] QUEEN_MAX  = 8'd47;
    localparam logic [7:0] KING_VAL   = 8'd48;

    typedef enum logic [2:0] {
        PAWN   = 3'd0,
        ROOK   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        QUEEN  = 3'd4,
        KING   = 3'd5
    } piece_type_e;

    localparam logic [3:0] CSR_CTRL   = 4'd0;
    localparam logic [3:0] CSR_BOARD  = 4'd1;
    localparam logic [3:0] CSR_DEST   = 4'd2;
    localparam logic [3:0] CSR_COLOUR = 4'd3;
    localparam logic [3:0] CSR_MAX    = 4'd4;

    localparam logic [2:0] GEN_REG_CTRL  = 3'd0;
    localparam logic [2:0] GEN_REG_BOARD = 3'd1;
    localparam logic [2:0] GEN_REG_DST   = 3'd2;
    localparam logic [2:0] GEN_REG_X     = 3'd3;
    localparam logic [2:0] GEN_REG_Y     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SCAN,
        S_CFG,
        S_POLL,
        S_DONE
    } state_e;

    function automatic logic [31:0] gen_addr(
        input piece_type_e t,
        input logic [2:0]  r
    );
        return GEN_BASE + 32'(t) * GEN_STRIDE
             + {27'b0, r, 2'b00};
    endfunction

endpackage

// File: rtl/movegen_dispatcher_piece_decode.sv
// Classifies one signed board square: whether it belongs to the
// requested colour and which generator handles it.
module piece_decode
    import movegen_pkg::*;
(
    input  logic [7:0]  sq_val_i,
    input  logic        colour_i,
    output logic        own_o,
    output piece_type_e type_o
);

    logic [7:0] mag;
    logic       valid;

    always_comb begin
        mag    = sq_val_i[7] ? (8'd0 - sq_val_i) : sq_val_i;
        type_o = PAWN;
        if (mag <= PAWN_MAX) begin
            type_o = PAWN;
        end else if (mag <= ROOK_MAX) begin
            type_o = ROOK;
        end else if (mag <= KNIGHT_MAX) begin
            type_o = KNIGHT;
        end else if (mag <= BISHOP_MAX) begin
            type_o = BISHOP;
        end else if (mag <= QUEEN_MAX) begin
            type_o = QUEEN;
        end else begin
            type_o = KING;
        end
        // Empty squares and out-of-range codes never dispatch
        valid = (mag != 8'd0) && (mag <= KING_VAL);
        own_o = valid && (colour_i ? sq_val_i[7] : !sq_val_i[7]);
    end

endmodule

// File: rtl/movegen_dispatcher.sv
// Walks one board, programs a generator per own piece and
// accumulates the number of boards the generators produced.
module movegen_dispatcher
    import movegen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        mem_waitrequest,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    input  logic        gen_waitrequest,
    output logic [31:0] gen_address,
    output logic        gen_read,
    input  logic [31:0] gen_readdata,
    output logic        gen_write,
    output logic [31:0] gen_writedata
);

    state_e      state_q, state_d;
    logic [6:0]  sq_q, sq_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [31:0] dst_q, dst_d;
    logic [2:0]  step_q, step_d;
    logic        acc_q, acc_d;
    logic [31:0] board_q, board_d;
    logic [31:0] dest_q, dest_d;
    logic        colour_q, colour_d;
    logic [7:0]  max_q, max_d;

    logic [7:0]  cur_byte;
    logic        own;
    piece_type_e ptype;
    logic        busy;
    logic        start;
    logic [6:0]  sq_inc;
    state_e      adv_state;
    logic [2:0]  cfg_reg;
    logic [2:0]  gen_reg;
    logic [31:0] cfg_data;
    logic [7:0]  n_boards;
    logic [8:0]  cnt_sum;
    logic [7:0]  cnt_sat;
    logic        limit_hit;
    logic        unused_gen;

    assign cur_byte   = word_q[{sq_q[1:0], 3'b000} +: 8];
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign start      = slave_write && (slave_address == CSR_CTRL)
                     && (state_q == S_IDLE);
    assign sq_inc     = sq_q + 7'd1;
    assign n_boards   = gen_readdata[7:0];
    assign unused_gen = ^gen_readdata[31:8];

    piece_decode u_decode (
        .sq_val_i (cur_byte),
        .colour_i (colour_q),
        .own_o    (own),
        .type_o   (ptype)
    );

    // Leaving a square: next lane, next word, or end of board
    always_comb begin
        adv_state = S_SCAN;
        if (sq_q[1:0] == 2'd3) begin
            adv_state = (sq_inc == 7'd64) ? S_DONE : S_FETCH;
        end
    end

    // Generator programming order is r=1..4 then r=0 (start)
    always_comb begin
        cfg_reg  = (step_q == 3'd4) ? GEN_REG_CTRL : step_q + 3'd1;
        cfg_data = 32'd0;
        case (cfg_reg)
            GEN_REG_BOARD: cfg_data = board_q;
            GEN_REG_DST:   cfg_data = dst_q;
            GEN_REG_X:     cfg_data = {29'b0, sq_q[2:0]};
            GEN_REG_Y:     cfg_data = {29'b0, sq_q[5:3]};
            default:       cfg_data = 32'd0;
        endcase
    end

    always_comb begin
        cnt_sum   = {1'b0, count_q} + {1'b0, n_boards};
        cnt_sat   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        limit_hit = (max_q != 8'd0) && (cnt_sat >= max_q);
    end

    always_comb begin
        state_d       = state_q;
        sq_d          = sq_q;
        word_d        = word_q;
        count_d       = count_q;
        ovf_d         = ovf_q;
        dst_d         = dst_q;
        step_d        = step_q;
        acc_d         = acc_q;
        mem_read      = 1'b0;
        gen_read      = 1'b0;
        gen_write     = 1'b0;
        gen_reg       = GEN_REG_CTRL;
        gen_writedata = 32'd0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    sq_d    = 7'd0;
                    count_d = 8'd0;
                    ovf_d   = 1'b0;
                    dst_d   = dest_q;
                    acc_d   = 1'b0;
                end
            end
            S_FETCH: begin
                mem_read = !acc_q;
                if (!acc_q && !mem_waitrequest) begin
                    acc_d = 1'b1;
                end
                if (acc_q && mem_readdatavalid) begin
                    word_d  = mem_readdata;
                    acc_d   = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (own) begin
                    state_d = S_CFG;
                    step_d  = 3'd0;
                end else begin
                    sq_d    = sq_inc;
                    state_d = adv_state;
                end
            end
            S_CFG: begin
                gen_write     = 1'b1;
                gen_reg       = cfg_reg;
                gen_writedata = cfg_data;
                if (!gen_waitrequest) begin
                    step_d = step_q + 3'd1;
                    if (step_q == 3'd4) begin
                        state_d = S_POLL;
                    end
                end
            end
            S_POLL: begin
                gen_read = 1'b1;
                if (!gen_waitrequest) begin
                    count_d = cnt_sat;
                    dst_d   = dst_q + {18'b0, n_boards, 6'b0};
                    if (limit_hit) begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sq_d    = sq_inc;
                        state_d = adv_state;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_address = board_q + {25'b0, sq_q};
    assign gen_address = gen_addr(ptype, gen_reg);

    always_comb begin
        board_d  = board_q;
        dest_d   = dest_q;
        colour_d = colour_q;
        max_d    = max_q;
        if (slave_write) begin
            case (slave_address)
                CSR_BOARD:  board_d  = slave_writedata;
                CSR_DEST:   dest_d   = slave_writedata;
                CSR_COLOUR: colour_d = slave_writedata[0];
                CSR_MAX:    max_d    = slave_writedata[7:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        slave_readdata = 32'd0;
        case (slave_address)
            CSR_CTRL:   slave_readdata = {ovf_q, 23'b0, count_q};
            CSR_BOARD:  slave_readdata = board_q;
            CSR_DEST:   slave_readdata = dest_q;
            CSR_COLOUR: slave_readdata = {31'b0, colour_q};
            CSR_MAX:    slave_readdata = {24'b0, max_q};
            default:    slave_readdata = 32'd0;
        endcase
    end

    // Status reads stall until the run reaches DONE
    assign slave_waitrequest = slave_read
                            && (slave_address == CSR_CTRL) && busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sq_q     <= 7'd0;
            word_q   <= 32'd0;
            count_q  <= 8'd0;
            ovf_q    <= 1'b0;
            dst_q    <= 32'd0;
            step_q   <= 3'd0;
            acc_q    <= 1'b0;
            board_q  <= 32'd0;
            dest_q   <= 32'd0;
            colour_q <= 1'b0;
            max_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            sq_q     <= sq_d;
            word_q   <= word_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            dst_q    <= dst_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            board_q  <= board_d;
            dest_q   <= dest_d;
            colour_q <= colour_d;
            max_q    <= max_d;
        end
    end

endmodule

// File: tb/tb_movegen_dispatcher.sv
// Scoreboard bench: stimulus queues the expected bus trace, a
// monitor pops and compares every accepted DUT transfer.
module tb_movegen_dispatcher;

    localparam logic [31:0] BOARD = 32'h2000_0000;

    logic        clk;
    logic        rst;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        gen_waitrequest;
    logic [31:0] gen_address;
    logic        gen_read;
    logic [31:0] gen_readdata;
    logic        gen_write;
    logic [31:0] gen_writedata;

    movegen_dispatcher dut (
        .clk               (clk),
        .rst               (rst),
        .slave_waitrequest (slave_waitrequest),
        .slave_address     (slave_address),
        .slave_read        (slave_read),
        .slave_readdata    (slave_readdata),
        .slave_write       (slave_write),
        .slave_writedata   (slave_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .gen_waitrequest   (gen_waitrequest),
        .gen_address       (gen_address),
        .gen_read          (gen_read),
        .gen_readdata      (gen_readdata),
        .gen_write         (gen_write),
        .gen_writedata     (gen_writedata)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } rd_t;

    txn_t exp_q[$];
    rd_t  exp_rd[$];

    int n_checks = 0;
    int n_pass   = 0;
    int mem_rd_cnt = 0;

    logic [7:0] brd[64];
    int         d_sq[16];
    int         d_ty[16];
    logic [7:0] d_n[16];
    int         nd;
    logic [3:0] ret_idx;
    logic       ret_clr;
    logic       hold_mem;
    logic       stall_en;
    logic       pend;
    logic [5:0] paddr;
    int         row0[8] = '{9, 19, 29, 39, 48, 30, 20, 10};
    int         typ0[8] = '{1, 2, 3, 4, 5, 3, 2, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cmp_txn(input logic [1:0] k,
                           input logic [31:0] a,
                           input logic [31:0] d);
        txn_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected txn: kind %0d addr %h", k, a);
        end else begin
            e = exp_q.pop_front();
            check("txn kind", {30'b0, k}, {30'b0, e.kind});
            check("txn addr", a, e.addr);
            if (k == 2'd1) check("txn data", d, e.data);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if ((mem_read && gen_read) || (mem_read && gen_write)
                || (gen_read && gen_write))
                check("strobe exclusivity", 32'd1, 32'd0);
            if (mem_read && !mem_waitrequest) begin
                mem_rd_cnt++;
                cmp_txn(2'd0, mem_address, 32'd0);
            end
            if (gen_write && !gen_waitrequest)
                cmp_txn(2'd1, gen_address, gen_writedata);
            if (gen_read && !gen_waitrequest)
                cmp_txn(2'd2, gen_address, 32'd0);
            if (slave_read && !slave_waitrequest) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected csr read: %h",
                             slave_readdata);
                end else begin
                    rd_t r;
                    r = exp_rd.pop_front();
                    check("csr addr", {28'b0, slave_address},
                          {28'b0, r.addr});
                    check("csr data", slave_readdata, r.data);
                end
            end
        end
    end

    // SDRAM mock: one outstanding read, data two edges later
    always @(posedge clk) begin
        if (rst) begin
            pend              <= 1'b0;
            mem_readdatavalid <= 1'b0;
        end else begin
            mem_readdatavalid <= 1'b0;
            if (pend) begin
                pend              <= 1'b0;
                mem_readdatavalid <= 1'b1;
                mem_readdata <= {brd[paddr + 6'd3], brd[paddr + 6'd2],
                                 brd[paddr + 6'd1], brd[paddr]};
            end
            if (mem_read && !mem_waitrequest) begin
                pend  <= 1'b1;
                paddr <= mem_address[5:0];
            end
        end
    end

    // Generator mock: reg0 returns the next entry of d_n
    always @(posedge clk) begin
        if (ret_clr) ret_idx <= 4'd0;
        else if (gen_read && !gen_waitrequest) ret_idx <= ret_idx + 4'd1;
    end
    assign gen_readdata = {24'b0, d_n[ret_idx]};

    initial begin
        mem_waitrequest = 1'b0;
        gen_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_waitrequest = hold_mem
                || (stall_en && ($urandom_range(0, 9) < 3));
            gen_waitrequest = stall_en && ($urandom_range(0, 9) < 3);
        end
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        slave_write     = 1'b1;
        slave_address   = a;
        slave_writedata = d;
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a);
        bit done;
        int c;
        done = 1'b0;
        c = 0;
        @(posedge clk);
        #1;
        slave_read    = 1'b1;
        slave_address = a;
        while (!done && c < 20000) begin
            @(negedge clk);
            done = !slave_waitrequest;
            @(posedge clk);
            c++;
        end
        #1;
        slave_read = 1'b0;
        if (!done) check("csr read timeout", 32'd1, 32'd0);
    endtask

    task automatic push_trace(input logic [31:0] dest,
                              input int stop_after);
        logic [31:0] d;
        logic [31:0] base;
        int k;
        d = dest;
        k = 0;
        for (int s = 0; s < 64; s++) begin
            if (s % 4 == 0) exp_q.push_back('{2'd0, BOARD + s, 32'd0});
            if (k < nd && d_sq[k] == s) begin
                base = 32'h1000 + d_ty[k] * 64;
                exp_q.push_back('{2'd1, base + 4, BOARD});
                exp_q.push_back('{2'd1, base + 8, d});
                exp_q.push_back('{2'd1, base + 12, 32'(s % 8)});
                exp_q.push_back('{2'd1, base + 16, 32'(s / 8)});
                exp_q.push_back('{2'd1, base, 32'd0});
                exp_q.push_back('{2'd2, base, 32'd0});
                d = d + {18'b0, d_n[k], 6'b0};
                k++;
                if (k == stop_after) return;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic col,
                          input logic [7:0] mx, input logic [31:0] dst,
                          input logic [31:0] exp_stat, input bit extra,
                          input int exp_reads);
        int r0;
        @(posedge clk);
        #1 ret_clr = 1'b1;
        @(posedge clk);
        #1 ret_clr = 1'b0;
        csr_write(4'd1, BOARD);
        csr_write(4'd2, dst);
        csr_write(4'd3, {31'b0, col});
        csr_write(4'd4, {24'b0, mx});
        r0 = mem_rd_cnt;
        csr_write(4'd0, 32'd1);
        if (extra) begin
            repeat (40) @(posedge clk);
            csr_write(4'd0, 32'd1);
        end
        exp_rd.push_back('{4'd0, exp_stat});
        csr_read(4'd0);
        check({tag, " mem reads"}, 32'(mem_rd_cnt - r0), 32'(exp_reads));
        check({tag, " trace drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) brd[i] = 8'd0;
    endtask

    task automatic init_board_black_list();
        clear_board();
        for (int x = 0; x < 8; x++) begin
            brd[x]      = 8'(row0[x]);
            brd[8 + x]  = 8'(x + 1);
            brd[48 + x] = 8'(-(x + 1));
            brd[56 + x] = 8'(-row0[x]);
        end
        nd = 16;
        for (int i = 0; i < 16; i++) begin
            d_sq[i] = 48 + i;
            d_ty[i] = (i < 8) ? 0 : typ0[i - 8];
            d_n[i]  = 8'd1;
        end
    endtask

    initial begin
        rst             = 1'b1;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_address   = 4'd0;
        slave_writedata = 32'd0;
        ret_clr         = 1'b1;
        hold_mem        = 1'b1;
        stall_en        = 1'b0;
        nd              = 0;
        for (int i = 0; i < 16; i++) d_n[i] = 8'd0;
        clear_board();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        ret_clr = 1'b0;

        // Reset in the middle of a stalled fetch
        csr_write(4'd1, BOARD);
        csr_write(4'd0, 32'd1);
        begin
            int c = 0;
            while (!mem_read && c < 20) begin
                @(negedge clk);
                c++;
            end
        end
        check("t1 fetch issued", {31'b0, mem_read}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t1 mem_read", {31'b0, mem_read}, 32'd0);
        check("t1 gen_read", {31'b0, gen_read}, 32'd0);
        check("t1 gen_write", {31'b0, gen_write}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        hold_mem = 1'b0;
        exp_rd.push_back('{4'd0, 32'd0});
        csr_read(4'd0);
        exp_rd.push_back('{4'd1, 32'd0});
        csr_read(4'd1);

        // Single white pawn at x=2, y=1
        clear_board();
        brd[10] = 8'd1;
        nd = 1;
        d_sq[0] = 10; d_ty[0] = 0; d_n[0] = 8'd2;
        push_trace(32'h3000_0000, 0);
        run_op("t2", 1'b0, 8'd0, 32'h3000_0000, 32'd2, 1'b0, 16);

        // Knight then bishop, destinations laid out contiguously
        clear_board();
        brd[1] = 8'd19;
        brd[2] = 8'd29;
        nd = 2;
        d_sq[0] = 1; d_ty[0] = 2; d_n[0] = 8'd3;
        d_sq[1] = 2; d_ty[1] = 3; d_n[1] = 8'd4;
        push_trace(32'h3000_0000, 0);
        run_op("t3", 1'b0, 8'd0, 32'h3000_0000, 32'd7, 1'b0, 16);

        // Black side of the starting position
        init_board_black_list();
        push_trace(32'h4000_0000, 0);
        run_op("t4", 1'b1, 8'd0, 32'h4000_0000, 32'd16, 1'b0, 16);

        // Board limit stops the run after the second dispatch
        clear_board();
        brd[0] = 8'd1;
        brd[1] = 8'd2;
        brd[2] = 8'd3;
        nd = 3;
        for (int i = 0; i < 3; i++) begin
            d_sq[i] = i; d_ty[i] = 0; d_n[i] = 8'd2;
        end
        push_trace(32'h3000_0000, 2);
        run_op("t5", 1'b0, 8'd3, 32'h3000_0000, 32'h8000_0004,
               1'b0, 1);

        // Random stalls plus a start while busy
        stall_en = 1'b1;
        init_board_black_list();
        push_trace(32'h4000_0000, 0);
        run_op("t6", 1'b1, 8'd0, 32'h4000_0000, 32'd16, 1'b1, 16);
        stall_en = 1'b0;
        repeat (20) @(posedge clk);
        check("t6 no restart", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
